// File: rtl/fd_pkg.sv
// fd_pkg: shared constants and helpers for the programmable frequency divider.
package fd_pkg;
   localparam int FD_WIDTH_DEF = 21;
   localparam int FD_DIV_DEF = (1 << FD_WIDTH_DEF) - 1;
   function automatic int fd_period(input int n);
      return n + 1;
   endfunction
endpackage

// File: rtl/fd_cnt.sv
// fd_cnt: up-counter that wraps to zero at div and reports the terminal cycle.
module fd_cnt
   import fd_pkg::*;
#(
   parameter int WIDTH = FD_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] div,
   output logic [WIDTH-1:0] cnt,
   output logic             term
);
   assign term = en && (cnt == div);
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (term || clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/fd_div_prog.sv
// fd_div_prog: programmable divider producing a clock-enable tick and a square wave.
// New ratios wait in a shadow register and are applied only at a terminal count.
module fd_div_prog
   import fd_pkg::*;
#(
   parameter int               WIDTH   = FD_WIDTH_DEF,
   parameter logic [WIDTH-1:0] DEF_DIV = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             div_ld,
   input  logic [WIDTH-1:0] div_in,
   output logic             tick,
   output logic             q_sq,
   output logic [WIDTH-1:0] cnt,
   output logic             ld_pend
);
   logic [WIDTH-1:0] div_q, shadow;
   logic             term, apply, clr;
   // A frozen divider has no terminal to wait for, so it applies a pending load at once.
   assign clr   = !en && ld_pend;
   assign apply = ld_pend && (term || !en);
   fd_cnt #(.WIDTH(WIDTH)) u_cnt (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .clr (clr),
      .div (div_q),
      .cnt (cnt),
      .term(term)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         div_q   <= DEF_DIV;
         shadow  <= DEF_DIV;
         ld_pend <= 1'b0;
         tick    <= 1'b0;
         q_sq    <= 1'b0;
      end else begin
         tick    <= term;
         q_sq    <= term ? ~q_sq : q_sq;
         div_q   <= apply ? shadow : div_q;
         shadow  <= div_ld ? div_in : shadow;
         ld_pend <= div_ld || (ld_pend && !apply);
      end
endmodule

// File: tb/tb_fd_div_prog.sv
// tb_fd_div_prog: scoreboard bench for fd_div_prog at WIDTH=4, DEF_DIV=15.
module tb_fd_div_prog;
   import fd_pkg::*;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       div_ld = 1'b0;
   logic [3:0] div_in = 4'd0;
   logic       tick, q_sq, ld_pend;
   logic [3:0] cnt;
   int         n_tot = 0;
   int         n_pass = 0;
   int         cyc;
   logic [3:0] m_cnt, m_divq, m_sh;
   logic       m_pend, m_tick, m_sq;
   logic [6:0] exp_q[$];

   fd_div_prog #(.WIDTH(4), .DEF_DIV(4'd15)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .div_ld (div_ld),
      .div_in (div_in),
      .tick   (tick),
      .q_sq   (q_sq),
      .cnt    (cnt),
      .ld_pend(ld_pend)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // Assert reset, check the reset state before any edge, release at a negedge.
   task automatic do_reset();
      rst = 1'b1;
      en = 1'b0;
      div_ld = 1'b0;
      div_in = 4'd0;
      #1;
      chk("rst_state", {tick, q_sq, ld_pend, cnt}, 7'd0);
      m_cnt = 0; m_divq = 15; m_sh = 15; m_pend = 0; m_tick = 0; m_sq = 0;
      exp_q.delete();
      cyc = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Drive one cycle at a negedge, predict the post-edge outputs, compare after the edge.
   task automatic step(input logic e, input logic l, input logic [3:0] d);
      logic trm;
      en = e;
      div_ld = l;
      div_in = d;
      trm = e && (m_cnt == m_divq);
      if (trm) begin
         m_cnt = 0; m_tick = 1; m_sq = !m_sq;
         if (m_pend) begin m_divq = m_sh; m_pend = 0; end
      end else if (e) begin
         m_cnt = m_cnt + 1; m_tick = 0;
      end else begin
         m_tick = 0;
         if (m_pend) begin m_divq = m_sh; m_pend = 0; m_cnt = 0; end
      end
      if (l) begin m_sh = d; m_pend = 1; end
      exp_q.push_back({m_tick, m_sq, m_pend, m_cnt});
      cyc++;
      @(posedge clk);
      #1;
      chk($sformatf("cyc%0d", cyc), {tick, q_sq, ld_pend, cnt}, exp_q.pop_front());
      @(negedge clk);
   endtask

   // Count enabled cycles up to and including the next tick.
   task automatic meas(input string tag, input int exp);
      int p = 0;
      do begin
         step(1, 0, 0);
         p++;
      end while (!tick && p < 40);
      chk(tag, p, exp);
   endtask

   initial begin
      int first, second, nt, mx;
      logic prev;
      #2;
      // Default ratio: ticks at 16 and 32, square wave follows.
      do_reset();
      first = 0; second = 0;
      for (int i = 1; i <= 40; i++) begin
         step(1, 0, 0);
         if (tick && first == 0) first = i;
         else if (tick && second == 0) second = i;
         if (i == 16) chk("sq_rise", q_sq, 1);
         if (i == 32) chk("sq_fall", q_sq, 0);
      end
      chk("tick_first", first, 16);
      chk("tick_second", second, 32);
      // Load 3 at cnt=5; it waits for the terminal at 15.
      do_reset();
      repeat (5) step(1, 0, 0);
      chk("p2_cnt5", cnt, 5);
      step(1, 1, 3);
      chk("p2_pend", ld_pend, 1);
      for (int i = 0; i < 20 && !tick; i++) step(1, 0, 0);
      chk("p2_term_cnt", cnt, 0);
      chk("p2_applied", ld_pend, 0);
      nt = 0; mx = 0;
      repeat (16) begin
         step(1, 0, 0);
         nt += int'(tick);
         if (int'(cnt) > mx) mx = int'(cnt);
      end
      chk("p2_ticks", nt, 4);
      chk("p2_max", mx, 3);
      // Divide-by-1: tick held high, square toggles each cycle.
      step(1, 1, 0);
      repeat (6) step(1, 0, 0);
      repeat (5) begin
         prev = q_sq;
         step(1, 0, 0);
         chk("p3_tick", tick, 1);
         chk("p3_sq", q_sq, !prev);
         chk("p3_cnt", cnt, 0);
      end
      // Last strobe wins.
      do_reset();
      repeat (3) step(1, 0, 0);
      step(1, 1, 7);
      repeat (2) step(1, 0, 0);
      step(1, 1, 2);
      chk("p4_pend", ld_pend, 1);
      for (int i = 0; i < 20 && !tick; i++) step(1, 0, 0);
      chk("p4_cleared", ld_pend, 0);
      meas("p4_per_a", fd_period(2));
      meas("p4_per_b", fd_period(2));
      // Load coinciding with a terminal while 9 is pending.
      do_reset();
      repeat (2) step(1, 0, 0);
      step(1, 1, 9);
      for (int i = 0; i < 40 && cnt != 15; i++) step(1, 0, 0);
      chk("p5_pre", cnt, 15);
      step(1, 1, 5);
      chk("p5_tick", tick, 1);
      chk("p5_pend", ld_pend, 1);
      meas("p5_per9", fd_period(9));
      chk("p5_pend_clr", ld_pend, 0);
      meas("p5_per5a", fd_period(5));
      meas("p5_per5b", fd_period(5));
      // Freeze at 7, resume, then asynchronous reset mid-cycle.
      do_reset();
      repeat (7) step(1, 0, 0);
      chk("p6_cnt7", cnt, 7);
      repeat (10) begin
         step(0, 0, 0);
         chk("p6_hold", cnt, 7);
         chk("p6_notick", tick, 0);
      end
      step(1, 0, 0);
      chk("p6_resume", cnt, 8);
      repeat (2) step(1, 0, 0);
      chk("p6_cnt10", cnt, 10);
      #2 rst = 1'b1;
      #1 chk("p6_async", {tick, q_sq, ld_pend, cnt}, 7'd0);
      @(negedge clk);
      rst = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
